io_input_ctrl: RTL
==================

Name: io_input_ctrl

Overview:
- Input-side peripheral for the pipelined core. Reads board switches (io_sw) and push-buttons (io_btn).
- Per input it does: 2-flop synchronisation, then debounce, then press-event latching.
- Presents results to the LSU as a small memory-mapped register file with registered reads, W1C event clearing and a level interrupt.
- Counterpart to the output peripherals (LEDR/LEDG/HEX/LCD): carries data from the board into the core.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive stable cycles needed to commit a new input value (board build overrides to 500000). Legal range is 2 or more.
- BTN_ACTIVE_LOW, 0, when 1, io_btn is inverted after synchronisation, so "pressed" always reads as 1 internally.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- io_sw  in  32  raw switch inputs, asynchronous to clk
- io_btn  in  4  raw button inputs, asynchronous to clk
- addr  in  4  byte offset within block; only addr[3:2] decoded
- rd_en  in  1  read strobe
- wr_en  in  1  write strobe
- wr_data  in  32  write data
- rd_data  out  32  read data, valid one cycle after rd_en
- irq  out  1  level interrupt: OR over bits of (btn_evt & irq_en)

Behaviour:
- Reset: while rst_n=0, all registers clear asynchronously. This covers sync flops, debounce counters, debounced values, btn_evt, irq_en, rd_data=0 and irq=0.
- Synchronisers: every input bit passes through sync1 then sync2.
  - Switches have an extra delayed copy, sync3.
- Button debounce uses one counter per bit:
  - If sync2 equals the debounced value: counter is set to 0.
  - Otherwise, counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs: the debounced value takes sync2 and the counter is set to 0.
- Button latency: a clean input step sampled at edge 1 appears in the debounced value at edge 2+DEBOUNCE_CYCLES.
  - A pulse shorter than DEBOUNCE_CYCLES cycles after sync is never committed.
- Switch debounce uses one shared counter for the whole vector:
  - If sync2 differs from sync3: counter is set to 0.
  - Else if sync2 differs from the debounced value: counter increments.
  - On reaching DEBOUNCE_CYCLES-1: the whole 32-bit vector commits.
- Switch latency: a clean step appears at edge 3+DEBOUNCE_CYCLES. Any further change on any bit restarts the count.
- Press events:
  - A button bit commits 0->1 on an edge: btn_evt[i] sets on that same edge.
  - Releases set nothing.
  - Events are sticky until cleared.
- Register map, selected by addr[3:2]. Unused rd_data bits read 0.
  - 0x0 SW: debounced switches, read-only.
  - 0x4 BTN: debounced button levels in bits [3:0], read-only.
  - 0x8 EVT: btn_evt[3:0]. Reads return the value. Writes clear each bit where wr_data is 1 (W1C).
  - 0xC IEN: irq_en[3:0], read/write.
  - Writes to 0x0 and 0x4 are ignored.
- Reads:
  - rd_data is registered: it takes the addressed value on the edge where rd_en=1.
  - On an edge where rd_en=0, rd_data is set to 0.
  - A read returns the pre-edge value, even when a write or event hits the same register on that edge.
- Simultaneous events:
  - If an event set and a W1C clear of the same bit land on the same edge, the set wins and the bit stays 1.
  - rd_en and wr_en together in one cycle are legal; both take effect.
- irq:
  - Driven from registers only; no combinational path from bus inputs.
  - Updates on the edge after btn_evt or irq_en changes.
- Reset mid-count: counters and pending events are lost. After release, inputs re-qualify from scratch.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=0):
1. Reset, then io_sw=1234 held -> a read at 0x0 returns 0 up to and including edge 6 after the change. From edge 7+1 onward (one read cycle) it returns 32'd1234. rd_data=0 on cycles without rd_en.
2. io_btn[2] pulse of 3 cycles -> BTN reads 0 throughout, btn_evt stays 0, irq stays 0.
3. io_btn[1] held high for 10 cycles with irq_en=4'b0010 written -> BTN=4'b0010 from edge 6, EVT=4'b0010, irq=1 one edge later. Then write 0x8 with 4'b0010 -> EVT=0 and irq=0 on the following edge.
4. Write W1C of bit 0 on the exact edge where btn0's press commits -> EVT bit 0 remains 1. A read issued on that edge returns the pre-edge value, 0.
5. io_sw bit 0 toggles every 2 cycles for 20 cycles, then settles at 1 -> SW never shows an intermediate value and becomes 1 exactly 7 edges after the final change.
6. Assert rst_n=0 mid-count with EVT=4'b1000 and irq_en=4'b1000 -> rd_data, irq, EVT and IEN are 0 immediately, without waiting for a clock edge. The held button re-commits 6 edges after release, and irq re-asserts only after IEN is rewritten.

Source files
------------

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: board switch / push-button input peripheral.
// Each input is synchronised (2 flops), debounced, and button presses are
// latched as sticky events. A small register file (SW, BTN, EVT, IEN) is
// exposed to the LSU with registered reads, W1C event clearing and a level irq.
module io_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_sw,
    input  logic [3:0]  io_btn,
    input  logic [3:0]  addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_SW  = 2'd0,
        REG_BTN = 2'd1,
        REG_EVT = 2'd2,
        REG_IEN = 2'd3
    } reg_sel_e;

    logic [31:0]          sw_sync1_q, sw_sync1_d;
    logic [31:0]          sw_sync2_q, sw_sync2_d;
    logic [31:0]          sw_sync3_q, sw_sync3_d;
    logic [3:0]           btn_sync1_q, btn_sync1_d;
    logic [3:0]           btn_sync2_q, btn_sync2_d;
    logic [CW-1:0]        sw_cnt_q, sw_cnt_d;
    logic [3:0][CW-1:0]   btn_cnt_q, btn_cnt_d;
    logic [31:0]          sw_deb_q, sw_deb_d;
    logic [3:0]           btn_deb_q, btn_deb_d;
    logic [3:0]           btn_evt_q, btn_evt_d;
    logic [3:0]           irq_en_q, irq_en_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 irq_q, irq_d;

    logic [3:0]           btn_level;
    logic [3:0]           btn_rise;
    logic [3:0]           evt_clr;
    logic [31:0]          rd_mux;
    reg_sel_e             reg_sel;
    logic                 unused_bits;

    assign unused_bits = ^{addr[1:0], wr_data[31:4]};

    // Synchroniser chains; switches keep a third copy to detect any change.
    always_comb begin
        sw_sync1_d  = io_sw;
        sw_sync2_d  = sw_sync1_q;
        sw_sync3_d  = sw_sync2_q;
        btn_sync1_d = io_btn;
        btn_sync2_d = btn_sync1_q;
        btn_level   = BTN_ACTIVE_LOW ? ~btn_sync2_q : btn_sync2_q;
    end

    // Per-button debounce: commit after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        btn_deb_d = btn_deb_q;
        btn_cnt_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (btn_level[i] != btn_deb_q[i]) begin
                if (btn_cnt_q[i] == CNT_LAST) begin
                    btn_deb_d[i] = btn_level[i];
                end else begin
                    btn_cnt_d[i] = btn_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Shared switch debounce: any bit still moving restarts the whole-vector count.
    always_comb begin
        sw_deb_d = sw_deb_q;
        sw_cnt_d = '0;
        if ((sw_sync2_q == sw_sync3_q) && (sw_sync2_q != sw_deb_q)) begin
            if (sw_cnt_q == CNT_LAST) begin
                sw_deb_d = sw_sync2_q;
            end else begin
                sw_cnt_d = sw_cnt_q + CW'(1);
            end
        end
    end

    // Bus side: event set/clear, interrupt enable, registered read mux and irq.
    always_comb begin
        reg_sel   = reg_sel_e'(addr[3:2]);
        btn_rise  = btn_deb_d & ~btn_deb_q;
        evt_clr   = (wr_en && reg_sel == REG_EVT) ? wr_data[3:0] : '0;
        // set is OR-ed in after the clear so a same-edge press survives W1C
        btn_evt_d = (btn_evt_q & ~evt_clr) | btn_rise;
        irq_en_d  = (wr_en && reg_sel == REG_IEN) ? wr_data[3:0] : irq_en_q;
        rd_mux    = '0;
        case (reg_sel)
            REG_SW:  rd_mux = sw_deb_q;
            REG_BTN: rd_mux = {28'd0, btn_deb_q};
            REG_EVT: rd_mux = {28'd0, btn_evt_q};
            REG_IEN: rd_mux = {28'd0, irq_en_q};
            default: rd_mux = '0;
        endcase
        rd_data_d = rd_en ? rd_mux : '0;
        irq_d     = |(btn_evt_q & irq_en_q);
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
            sw_sync3_q  <= '0;
            btn_sync1_q <= '0;
            btn_sync2_q <= '0;
            sw_cnt_q    <= '0;
            btn_cnt_q   <= '0;
            sw_deb_q    <= '0;
            btn_deb_q   <= '0;
            btn_evt_q   <= '0;
            irq_en_q    <= '0;
            rd_data_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            sw_sync1_q  <= sw_sync1_d;
            sw_sync2_q  <= sw_sync2_d;
            sw_sync3_q  <= sw_sync3_d;
            btn_sync1_q <= btn_sync1_d;
            btn_sync2_q <= btn_sync2_d;
            sw_cnt_q    <= sw_cnt_d;
            btn_cnt_q   <= btn_cnt_d;
            sw_deb_q    <= sw_deb_d;
            btn_deb_q   <= btn_deb_d;
            btn_evt_q   <= btn_evt_d;
            irq_en_q    <= irq_en_d;
            rd_data_q   <= rd_data_d;
            irq_q       <= irq_d;
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = irq_q;

endmodule
